// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: merges pipeline writeback with buffered long-latency results
// and keeps a per-register busy scoreboard. Optional macro WB_BYPASS_EN enables the lr->RF bypass.
module rf_wb_arbiter #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 32,
    parameter int unsigned AW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pipe_we,
    input  logic [AW-1:0] pipe_waddr,
    input  logic [DW-1:0] pipe_wdata,
    output logic          pipe_stall,
    input  logic          lr_valid,
    output logic          lr_ready,
    input  logic [AW-1:0] lr_waddr,
    input  logic [DW-1:0] lr_wdata,
    input  logic          rsv_valid,
    input  logic [AW-1:0] rsv_addr,
    output logic [31:0]   busy,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    logic [AW-1:0] mem_addr [DEPTH];
    logic [DW-1:0] mem_data [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          full;
    logic          empty;
    logic          pipe_valid;
    logic          lr_fire;
    logic          push;
    logic          pop;
    logic          take_pipe;
    logic          bypass;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_data;
    logic          nx_we;
    logic [AW-1:0] nx_addr;
    logic [DW-1:0] nx_data;
    logic [31:0]   busy_nx;

    // Winner selection, handshake and scoreboard next state
    always_comb begin
        full       = (count == CW'(DEPTH));
        empty      = (count == '0);
        pipe_valid = pipe_we && (pipe_waddr != '0);
        lr_ready   = !full && !rst;
        lr_fire    = lr_valid && lr_ready;
        head_addr  = mem_addr[rd_ptr];
        head_data  = mem_data[rd_ptr];
        pipe_stall = 1'b0;
        pop        = 1'b0;
        take_pipe  = 1'b0;
        bypass     = 1'b0;

        if (full) begin
            pop        = 1'b1;
            pipe_stall = pipe_we && !rst;
        end else if (pipe_valid) begin
            take_pipe = 1'b1;
        end else if (!empty) begin
            pop = 1'b1;
        end
`ifdef WB_BYPASS_EN
        else if (lr_fire && (lr_waddr != '0)) begin
            bypass = 1'b1;
        end
`endif

        // Results for r0 are accepted but never reach the FIFO
        push = lr_fire && (lr_waddr != '0) && !bypass;

        nx_we   = 1'b0;
        nx_addr = rf_waddr;
        nx_data = rf_wdata;
        if (take_pipe) begin
            nx_we   = 1'b1;
            nx_addr = pipe_waddr;
            nx_data = pipe_wdata;
        end else if (pop) begin
            nx_we   = 1'b1;
            nx_addr = head_addr;
            nx_data = head_data;
        end else if (bypass) begin
            nx_we   = 1'b1;
            nx_addr = lr_waddr;
            nx_data = lr_wdata;
        end

        busy_nx = busy;
        if (pop) begin
            busy_nx[head_addr] = 1'b0;
        end
        if (bypass) begin
            busy_nx[lr_waddr] = 1'b0;
        end
        if (rsv_valid) begin
            busy_nx[rsv_addr] = 1'b1;
        end
        busy_nx[0] = 1'b0;
    end

    // Control state and registered RF port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            busy     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            rf_we    <= nx_we;
            rf_waddr <= nx_addr;
            rf_wdata <= nx_data;
            busy     <= busy_nx;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // FIFO payload storage needs no reset; occupancy is tracked by count
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= lr_waddr;
            mem_data[wr_ptr] <= lr_wdata;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_rf_wb_arbiter;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          pipe_we;
    logic [AW-1:0] pipe_waddr;
    logic [DW-1:0] pipe_wdata;
    logic          pipe_stall;
    logic          lr_valid;
    logic          lr_ready;
    logic [AW-1:0] lr_waddr;
    logic [DW-1:0] lr_wdata;
    logic          rsv_valid;
    logic [AW-1:0] rsv_addr;
    logic [31:0]   busy;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;

    rf_wb_arbiter #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata), .pipe_stall(pipe_stall),
        .lr_valid(lr_valid), .lr_ready(lr_ready), .lr_waddr(lr_waddr), .lr_wdata(lr_wdata),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .busy(busy),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    endtask

    // Reference model: pending results as a plain ordered queue
    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          q[$];
    ent_t          e;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [31:0]   m_busy;
    logic [31:0]   nb;
    int            n;
    bit            pv;
    bit            rdy;
    bit            byp;

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            m_we = 1'b0; m_addr = '0; m_data = '0; m_busy = '0;
            chk("rst_rf_we", 32'(rf_we), 32'd0);
            chk("rst_busy", busy, 32'd0);
            chk("rst_lr_ready", 32'(lr_ready), 32'd0);
            chk("rst_pipe_stall", 32'(pipe_stall), 32'd0);
        end else begin
            n   = q.size();
            pv  = pipe_we && (pipe_waddr != 0);
            rdy = (n < DEPTH);
            chk("rf_we", 32'(rf_we), 32'(m_we));
            chk("rf_waddr", 32'(rf_waddr), 32'(m_addr));
            chk("rf_wdata", rf_wdata, m_data);
            chk("busy", busy, m_busy);
            chk("lr_ready", 32'(lr_ready), 32'(rdy));
            chk("pipe_stall", 32'(pipe_stall), 32'((n == DEPTH) && pipe_we));
            nb   = m_busy;
            m_we = 1'b0;
            byp  = 1'b0;
            if (n == DEPTH || (!pv && n > 0)) begin
                e = q.pop_front();
                m_we = 1'b1; m_addr = e.a; m_data = e.d;
                nb[e.a] = 1'b0;
            end else if (pv) begin
                m_we = 1'b1; m_addr = pipe_waddr; m_data = pipe_wdata;
            end else if (BYP && lr_valid && lr_waddr != 0) begin
                byp = 1'b1;
                m_we = 1'b1; m_addr = lr_waddr; m_data = lr_wdata;
                nb[lr_waddr] = 1'b0;
            end
            if (lr_valid && rdy && lr_waddr != 0 && !byp) q.push_back({lr_waddr, lr_wdata});
            if (rsv_valid) nb[rsv_addr] = 1'b1;
            nb[0] = 1'b0;
            m_busy = nb;
        end
    end

    task automatic idle();
        pipe_we = 1'b0; pipe_waddr = '0; pipe_wdata = '0;
        lr_valid = 1'b0; lr_waddr = '0; lr_wdata = '0;
        rsv_valid = 1'b0; rsv_addr = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        tick();
        chk("init_rf_we", 32'(rf_we), 32'd0);
        chk("init_busy", busy, 32'd0);
        chk("init_lr_ready", 32'(lr_ready), 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_lr_ready", 32'(lr_ready), 32'd1);

        // Plain pipeline write, then a write to r0
        pipe_we = 1'b1; pipe_waddr = 5'd5; pipe_wdata = 32'hDEADBEEF;
        #1 chk("t2_stall", 32'(pipe_stall), 32'd0);
        tick();
        chk("t2_we", 32'(rf_we), 32'd1);
        chk("t2_addr", 32'(rf_waddr), 32'd5);
        chk("t2_data", rf_wdata, 32'hDEADBEEF);
        pipe_waddr = 5'd0; pipe_wdata = 32'h00001234;
        tick();
        chk("t2_r0_we", 32'(rf_we), 32'd0);
        chk("t2_r0_hold", 32'(rf_waddr), 32'd5);
        idle();
        tick();

        // Pending long-latency result waits for the pipeline to go idle
        rsv_valid = 1'b1; rsv_addr = 5'd9;
        tick();
        chk("t3_busy_set", busy, 32'h0000_0200);
        rsv_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pipe_we = 1'b1; pipe_waddr = 5'd3; pipe_wdata = 32'(i);
            lr_valid = (i == 0); lr_waddr = 5'd9; lr_wdata = 32'h12345678;
            tick();
            chk("t3_pipe_addr", 32'(rf_waddr), 32'd3);
            chk("t3_busy9", 32'(busy[9]), 32'd1);
        end
        idle();
        tick();
        chk("t3_lr_we", 32'(rf_we), 32'd1);
        chk("t3_lr_addr", 32'(rf_waddr), 32'd9);
        chk("t3_lr_data", rf_wdata, 32'h12345678);
        chk("t3_busy_clr", busy, 32'd0);

        // Fill the FIFO behind a busy pipeline, then drain
        for (int k = 1; k <= 4; k++) begin
            rsv_valid = 1'b1; rsv_addr = 5'(k);
            tick();
        end
        rsv_valid = 1'b0;
        chk("t4_busy", busy, 32'h0000_001E);
        for (int k = 0; k < 4; k++) begin
            pipe_we = 1'b1; pipe_waddr = 5'd7; pipe_wdata = 32'h77;
            lr_valid = 1'b1; lr_waddr = 5'(k + 1); lr_wdata = 32'h100 + 32'(k + 1);
            #1 chk("t4_ready_hi", 32'(lr_ready), 32'd1);
            tick();
            chk("t4_pipe_addr", 32'(rf_waddr), 32'd7);
        end
        lr_valid = 1'b0;
        #1;
        chk("t4_ready_lo", 32'(lr_ready), 32'd0);
        chk("t4_stall", 32'(pipe_stall), 32'd1);
        tick();
        chk("t4_r1_addr", 32'(rf_waddr), 32'd1);
        chk("t4_r1_data", rf_wdata, 32'h101);
        chk("t4_busy_r1", busy, 32'h0000_001C);
        chk("t4_unstall", 32'(pipe_stall), 32'd0);
        tick();
        chk("t4_r7_addr", 32'(rf_waddr), 32'd7);
        idle();
        for (int k = 2; k <= 4; k++) begin
            tick();
            chk("t4_drain_addr", 32'(rf_waddr), 32'(k));
            chk("t4_drain_data", rf_wdata, 32'h100 + 32'(k));
        end
        chk("t4_busy_end", busy, 32'd0);

        // Reservation in the same cycle as the commit to that register
        rsv_valid = 1'b1; rsv_addr = 5'd6;
        tick();
        rsv_valid = 1'b0;
        pipe_we = 1'b1; pipe_waddr = 5'd3; pipe_wdata = 32'h3;
        lr_valid = 1'b1; lr_waddr = 5'd6; lr_wdata = 32'h66;
        tick();
        idle();
        rsv_valid = 1'b1; rsv_addr = 5'd6;
        tick();
        rsv_valid = 1'b0;
        chk("t5_commit_addr", 32'(rf_waddr), 32'd6);
        chk("t5_busy6", busy, 32'h0000_0040);
        lr_valid = 1'b1; lr_waddr = 5'd6; lr_wdata = 32'h67;
        tick();
        idle();
        tick();
        tick();
        chk("t5_busy_clean", busy, 32'd0);

        // Single result into an empty FIFO with an idle pipeline
        lr_valid = 1'b1; lr_waddr = 5'd8; lr_wdata = 32'hA5A5A5A5;
        tick();
        idle();
        chk("t6_we_first", 32'(rf_we), 32'(BYP));
        tick();
        chk("t6_we_second", 32'(rf_we), 32'(!BYP));
        chk("t6_addr", 32'(rf_waddr), 32'd8);
        chk("t6_data", rf_wdata, 32'hA5A5A5A5);
        tick();

        // Reset while three results are pending
        rsv_valid = 1'b1; rsv_addr = 5'd10;
        tick();
        rsv_addr = 5'd11;
        tick();
        rsv_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            pipe_we = 1'b1; pipe_waddr = 5'd3; pipe_wdata = 32'h33;
            lr_valid = 1'b1; lr_waddr = 5'(10 + k); lr_wdata = 32'hA00 + 32'(k);
            tick();
        end
        lr_valid = 1'b0;
        #1;
        chk("t1_busy_pre", busy, 32'h0000_0C00);
        chk("t1_we_pre", 32'(rf_we), 32'd1);
        rst = 1'b1;
        #1;
        chk("t1_rst_we", 32'(rf_we), 32'd0);
        chk("t1_rst_busy", busy, 32'd0);
        chk("t1_rst_ready", 32'(lr_ready), 32'd0);
        chk("t1_rst_stall", 32'(pipe_stall), 32'd0);
        tick();
        rst = 1'b0;
        idle();
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t1_no_stale", 32'(rf_we), 32'd0);
            chk("t1_ready", 32'(lr_ready), 32'd1);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
